// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: decode/EX/MEM register info toward the controller,
// pipeline-register write/flush/bubble controls and forward selects back to the core.
interface hazard_controller_if #(
  parameter int STALL_CNT_W = 16
);
  logic [2:0]             id_rs1;
  logic [2:0]             id_rs2;
  logic                   id_use_rs1;
  logic                   id_use_rs2;
  logic [2:0]             ex_rd;
  logic                   ex_reg_write;
  logic                   ex_mem_read;
  logic [2:0]             mem_rd;
  logic                   mem_reg_write;
  logic                   jump;
  logic                   mem_req;
  logic                   mem_ready;
  logic                   pc_write;
  logic                   ifid_write;
  logic                   ifid_flush;
  logic                   idex_write;
  logic                   idex_bubble;
  logic                   exmem_write;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, jump, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
           fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write, ex_mem_read,
           mem_rd, mem_reg_write, jump, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
           fwd_a, fwd_b, stall_count
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 16-bit MISC-V core: memory freeze, data stalls,
// post-jump IF/ID flush and a saturating stall counter. Define HAZARD_FORWARD_EN for forwarding.
module hazard_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [2:0]             flush_cnt_q, flush_cnt_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic       load_use, data_stall, freeze, flush_live;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write;
  logic [1:0] fwd_a, fwd_b;

  // Register 0 is hardwired, so it never participates in a dependency.
  function automatic logic reg_match(input logic [2:0] src, input logic [2:0] dst,
                                     input logic en);
    return en && (src != 3'd0) && (src == dst);
  endfunction

  always_comb begin
    ex_hit_a   = reg_match(hz.id_rs1, hz.ex_rd, hz.id_use_rs1 & hz.ex_reg_write);
    ex_hit_b   = reg_match(hz.id_rs2, hz.ex_rd, hz.id_use_rs2 & hz.ex_reg_write);
    mem_hit_a  = reg_match(hz.id_rs1, hz.mem_rd, hz.id_use_rs1 & hz.mem_reg_write);
    mem_hit_b  = reg_match(hz.id_rs2, hz.mem_rd, hz.id_use_rs2 & hz.mem_reg_write);
    load_use   = hz.ex_mem_read &
                 (reg_match(hz.id_rs1, hz.ex_rd, hz.id_use_rs1) |
                  reg_match(hz.id_rs2, hz.ex_rd, hz.id_use_rs2));
    freeze     = hz.mem_req & ~hz.mem_ready;
    flush_live = (state_q != RUN) && (flush_cnt_q != 3'd0);

`ifdef HAZARD_FORWARD_EN
    data_stall = load_use;
    fwd_a      = ex_hit_a ? 2'd1 : (mem_hit_a ? 2'd2 : 2'd0);
    fwd_b      = ex_hit_b ? 2'd1 : (mem_hit_b ? 2'd2 : 2'd0);
`else
    data_stall = load_use | ex_hit_a | ex_hit_b | mem_hit_a | mem_hit_b;
    fwd_a      = 2'd0;
    fwd_b      = 2'd0;
`endif

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    exmem_write = 1'b1;
    flush_cnt_d = flush_cnt_q;
    state_d     = RUN;

    // A stalled jump is dropped here; decode presents it again once IF/ID is released.
    if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_d     = MEMWAIT;
    end else if (data_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = flush_live ? FLUSH : RUN;
    end else if (hz.jump) begin
      ifid_flush  = 1'b1;
      flush_cnt_d = FLUSH_LOAD;
      state_d     = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
    end else if (flush_live) begin
      ifid_flush  = 1'b1;
      flush_cnt_d = flush_cnt_q - 3'd1;
      state_d     = (flush_cnt_d != 3'd0) ? FLUSH : RUN;
    end

    if (rst) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_bubble = 1'b0;
      exmem_write = 1'b1;
      fwd_a       = 2'd0;
      fwd_b       = 2'd0;
    end

    stall_count_d = stall_count_q;
    if (!pc_write && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      flush_cnt_q   <= 3'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_write  = idex_write;
  assign hz.idex_bubble = idex_bubble;
  assign hz.exmem_write = exmem_write;
  assign hz.fwd_a       = fwd_a;
  assign hz.fwd_b       = fwd_b;
  assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller (FLUSH_CYCLES=3): the driver queues expected
// controls per cycle, the monitor checks them on the falling edge.
module tb_hazard_controller;

  localparam int FC = 3;
  localparam int CW = 16;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Control vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write
  localparam logic [5:0] N = 6'b110101;
  localparam logic [5:0] S = 6'b000111;
  localparam logic [5:0] F = 6'b111101;
  localparam logic [5:0] Z = 6'b000000;

  typedef struct {
    string         name;
    logic [5:0]    ctl;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_t          sb[$];
  exp_t          e;
  logic [5:0]    got_ctl;
  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] model_cnt = '0;

  hazard_controller_if #(.STALL_CNT_W(CW)) hz();

  hazard_controller #(.FLUSH_CYCLES(FC), .STALL_CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string name, input logic r,
                     input logic [2:0] rs1, input logic u1, input logic [2:0] rs2, input logic u2,
                     input logic [2:0] exrd, input logic exrw, input logic exmr,
                     input logic [2:0] memrd, input logic memrw,
                     input logic jmp, input logic mreq, input logic mrdy,
                     input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
    exp_t x;
    @(posedge clk);
    #1;
    rst              = r;
    hz.id_rs1        = rs1;
    hz.id_use_rs1    = u1;
    hz.id_rs2        = rs2;
    hz.id_use_rs2    = u2;
    hz.ex_rd         = exrd;
    hz.ex_reg_write  = exrw;
    hz.ex_mem_read   = exmr;
    hz.mem_rd        = memrd;
    hz.mem_reg_write = memrw;
    hz.jump          = jmp;
    hz.mem_req       = mreq;
    hz.mem_ready     = mrdy;
    if (r) model_cnt = '0;
    x.name = name;
    x.ctl  = ctl;
    x.fa   = fa;
    x.fb   = fb;
    x.cnt  = model_cnt;
    sb.push_back(x);
    if (!r && !ctl[5] && model_cnt != '1) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic idle(input string name, input logic [5:0] ctl);
    cyc(name, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,
        ctl, 2'd0, 2'd0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got_ctl = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_write, hz.idex_bubble,
                 hz.exmem_write};
      total++;
      if (got_ctl !== e.ctl) begin
        bad++;
        $display("[TB] FAIL %s ctl got=%b exp=%b", e.name, got_ctl, e.ctl);
      end
      total++;
      if ({hz.fwd_a, hz.fwd_b} !== {e.fa, e.fb}) begin
        bad++;
        $display("[TB] FAIL %s fwd got=%0d/%0d exp=%0d/%0d", e.name, hz.fwd_a, hz.fwd_b,
                 e.fa, e.fb);
      end
      total++;
      if (hz.stall_count !== e.cnt) begin
        bad++;
        $display("[TB] FAIL %s stall_count got=%0d exp=%0d", e.name, hz.stall_count, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    hz.id_rs1 = 3'd0; hz.id_use_rs1 = 1'b0; hz.id_rs2 = 3'd0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = 3'd0; hz.ex_reg_write = 1'b0; hz.ex_mem_read = 1'b0;
    hz.mem_rd = 3'd0; hz.mem_reg_write = 1'b0;
    hz.jump = 1'b0; hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

    // Reset forces benign controls even with a load-use, jump and freeze presented.
    cyc("reset_forced", 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0,
        1'b1, 1'b1, 1'b0, N, 2'd0, 2'd0);
    idle("idle0", N);
    cyc("load_use", 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0,
        1'b0, 1'b0, 1'b0, S, FWD ? 2'd1 : 2'd0, 2'd0);
    idle("after_load", N);
    cyc("reg_zero", 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0,
        1'b0, 1'b0, 1'b0, N, 2'd0, 2'd0);
    cyc("raw_ex", 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0,
        1'b0, 1'b0, 1'b0, FWD ? N : S, 2'd0, FWD ? 2'd1 : 2'd0);
    cyc("raw_both", 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd5, 1'b1,
        1'b0, 1'b0, 1'b0, FWD ? N : S, FWD ? 2'd1 : 2'd0, 2'd0);
    cyc("raw_mem", 1'b0, 3'd6, 1'b1, 3'd6, 1'b1, 3'd1, 1'b1, 1'b0, 3'd6, 1'b1,
        1'b0, 1'b0, 1'b0, FWD ? N : S, FWD ? 2'd2 : 2'd0, FWD ? 2'd2 : 2'd0);
    cyc("no_use", 1'b0, 3'd2, 1'b0, 3'd2, 1'b0, 3'd2, 1'b1, 1'b1, 3'd2, 1'b1,
        1'b0, 1'b0, 1'b0, N, 2'd0, 2'd0);
    cyc("no_write", 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd2, 1'b0, 1'b0, 3'd2, 1'b0,
        1'b0, 1'b0, 1'b0, N, 2'd0, 2'd0);

    cyc("jump", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0,
        1'b1, 1'b0, 1'b0, F, 2'd0, 2'd0);
    idle("flush2", F);
    idle("flush3", F);
    idle("flush_done", N);

    cyc("jump_vs_stall", 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0,
        1'b1, 1'b0, 1'b0, S, FWD ? 2'd1 : 2'd0, 2'd0);
    idle("jump_dropped", N);

    cyc("jump_freeze", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0,
        1'b1, 1'b0, 1'b0, F, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cyc("freeze", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0,
          1'b0, 1'b1, 1'b0, Z, 2'd0, 2'd0);
    end
    cyc("mem_done_flush", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0,
        1'b0, 1'b1, 1'b1, F, 2'd0, 2'd0);
    idle("resume_flush", F);
    idle("resume_done", N);

    cyc("reload_jump1", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0,
        1'b1, 1'b0, 1'b0, F, 2'd0, 2'd0);
    idle("reload_mid", F);
    cyc("reload_jump2", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0,
        1'b1, 1'b0, 1'b0, F, 2'd0, 2'd0);
    idle("reload_f2", F);
    idle("reload_f3", F);
    idle("reload_done", N);

    cyc("req_and_ready", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0,
        1'b0, 1'b1, 1'b1, N, 2'd0, 2'd0);
    cyc("freeze_over_stall", 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0,
        1'b1, 1'b1, 1'b0, Z, FWD ? 2'd1 : 2'd0, 2'd0);
    idle("after_freeze", N);

    // Reset mid-MEMWAIT with flush pending: the pending flush must be abandoned.
    cyc("jump_pre_reset", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0,
        1'b1, 1'b0, 1'b0, F, 2'd0, 2'd0);
    cyc("freeze_pre_reset", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0,
        1'b0, 1'b1, 1'b0, Z, 2'd0, 2'd0);
    cyc("reset_in_memwait", 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0,
        1'b0, 1'b1, 1'b0, N, 2'd0, 2'd0);
    idle("post_reset_run", N);
    idle("post_reset_idle", N);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain pending got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the 16-bit MISC-V core. It sits beside the decode stage and drives the write-enable, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It covers:
- load-use and read-after-write (RAW) stalls;
- post-jump IF/ID flushes;
- full-pipeline freezes while a data-memory access is not ready.

It also counts stall cycles for performance debug.

## Interface
- FLUSH_CYCLES, 1, number of cycles `ifid_flush` is held after an accepted jump (1..7).
- STALL_CNT_W, 16, width of the stall-cycle counter.

- CLK  in  1  pipeline clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  3 each  source register fields of the instruction in ID (ir[8:6], ir[11:9]).
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rd  in  3  destination register of the instruction in EX.
- ex_reg_write  in  1  EX instruction writes `ex_rd`.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  3  destination register of the instruction in MEM.
- mem_reg_write  in  1  MEM instruction writes `mem_rd`.
- jump  in  1  taken branch/jump resolved in ID this cycle.
- mem_req  in  1  MEM stage has a data-memory access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID captures a NOP.
- idex_write  out  1  ID/EX write enable.
- idex_bubble  out  1  ID/EX captures a NOP (control bits zeroed).
- exmem_write  out  1  EX/MEM and MEM/WB write enable.
- fwd_a, fwd_b  out  2 each  ALU operand forward select: 0 register file, 1 from EX/MEM, 2 from MEM/WB.
- stall_count  out  STALL_CNT_W  saturating count of cycles with `pc_write`=0.

## Operation
- States:
  - RUN: normal operation.
  - FLUSH: flush counter non-zero.
  - MEMWAIT: memory freeze.
- A register match requires equal 3-bit fields, a non-zero register number, and the relevant use/write flag set. Register 0 never causes a hazard.
- Priority within a cycle, highest first: memory freeze > data stall > jump.
- Memory freeze:
  - Condition: `mem_req` and not `mem_ready`, in any state.
  - Effect: `pc_write`, `ifid_write`, `idex_write` and `exmem_write` are all 0. No flush or bubble; the flush counter holds.
  - Next state: MEMWAIT.
  - Leaves MEMWAIT the cycle `mem_ready`=1. Returns to FLUSH if the counter is non-zero, otherwise RUN.
- Load-use stall:
  - Condition: `ex_mem_read`, and `ex_rd` matches a used `id_rs1` or `id_rs2`.
  - Effect: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
  - Combinational. Lasts one cycle per occurrence, since the load leaves EX.
- Jump:
  - Condition: `jump` with no higher-priority condition.
  - Effect: `ifid_flush`=1 in the jump cycle, then for FLUSH_CYCLES-1 more cycles; the counter is loaded with FLUSH_CYCLES-1.
  - A jump shadowed by a stall is not recorded. Decode re-presents it because IF/ID is held.
  - A jump while in FLUSH reloads the counter.
- Otherwise all write enables are 1, and flush/bubble are 0.
- `stall_count` increments on every rising edge where `pc_write`=0, and saturates at all-ones.

## Timing
- Hazard outputs are combinational from the current inputs and state, and take effect at the next rising edge.
- Memory freeze, load-use stall and jump flush all apply in the same cycle their condition is seen (zero-cycle detection latency).
- Reset (asynchronous, active-high):
  - State RUN, flush counter 0, `stall_count` 0.
  - While `Reset`=1, outputs are forced to: all write enables 1, `ifid_flush`=0, `idex_bubble`=0, `fwd_a`=`fwd_b`=0.
- A `Reset` asserted mid-FLUSH or mid-MEMWAIT abandons the sequence immediately. The first cycle after release is RUN.
- `mem_req` and `mem_ready` both 1 in the same cycle means no freeze.

## Configuration
- HAZARD_FORWARD_EN defined:
  - Forwarding active. `fwd_a`/`fwd_b` select 1 on an `ex_rd` match, otherwise 2 on a `mem_rd` match; the EX/MEM match wins.
  - Only load-use causes a data stall.
- HAZARD_FORWARD_EN undefined:
  - `fwd_a`=`fwd_b`=0 at all times.
  - A data stall also fires on any used source matching `ex_rd` (with `ex_reg_write`) or `mem_rd` (with `mem_reg_write`), with the same stall outputs as load-use.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=3, `id_rs1`=3, `id_use_rs1`=1 → one cycle of `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; `stall_count` becomes 1.
- Register 0: `ex_mem_read`=1, `ex_rd`=0, `id_rs2`=0 → no stall, all enables 1.
- Jump with FLUSH_CYCLES=2: `jump` pulsed one cycle → `ifid_flush`=1 for exactly 2 cycles, `pc_write`=1 throughout.
- Memory freeze mid-flush: FLUSH_CYCLES=3, jump, then `mem_req`=1 with `mem_ready`=0 for 4 cycles:
  - during the freeze: all enables 0, `ifid_flush`=0, counter held;
  - after `mem_ready`: the remaining flush cycles complete;
  - `stall_count`=4.
- Forwarding, with HAZARD_FORWARD_EN: `ex_rd`=mem_rd=5, both writing, `id_rs1`=5 → `fwd_a`=1 and no stall. Without the macro → one stall cycle and `fwd_a`=0.
- Async reset during MEMWAIT → outputs return to reset values before the next clock edge; `stall_count`=0.
